// File: rtl/fetch_line_buffer_pkg.sv
// rtl/fetch_line_buffer_pkg.sv - shared fetch types: line queue entry, request FSM states, line geometry
package FetchTypes;

    localparam int FETCH_LINE_SIZE   = 8;
    localparam int FETCH_PADDR_WIDTH = 32;
    localparam int WORDS_PER_LINE    = FETCH_LINE_SIZE / 4;
    localparam int FETCH_START_W     = (WORDS_PER_LINE > 1) ? $clog2(WORDS_PER_LINE) : 1;

    typedef struct packed {
        logic [FETCH_PADDR_WIDTH-1:0]   lineAddr;
        logic [FETCH_LINE_SIZE*8-1:0]   line;
        logic [FETCH_START_W-1:0]       startWord;
    } FetchLineEntry;

    typedef enum logic [1:0] {
        Issue  = 2'd0,
        Wait   = 2'd1,
        Refill = 2'd2
    } FetchState;

endpackage

// File: rtl/fetch_line_queue.sv
// rtl/fetch_line_queue.sv - synchronous FIFO of fetched lines; flush wins over enqueue
module fetch_line_queue #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_enq,
    input  logic [WIDTH-1:0]           i_enq_data,
    input  logic                       i_deq,
    input  logic                       i_flush,
    output logic [WIDTH-1:0]           o_head,
    output logic [WIDTH-1:0]           o_next,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_empty,
    output logic                       o_full
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W:0]   r_count;
    logic             w_do_enq;
    logic             w_do_deq;

    assign o_empty  = (r_count == '0);
    assign o_full   = (r_count == (PTR_W+1)'(DEPTH));
    assign o_count  = r_count;
    assign o_head   = r_mem[r_rd_ptr];
    assign o_next   = r_mem[r_rd_ptr + 1'b1];
    assign w_do_enq = i_enq && !o_full && !i_flush;
    assign w_do_deq = i_deq && !o_empty && !i_flush;

    always_ff @(posedge clk) begin
        if (w_do_enq) begin
            r_mem[r_wr_ptr] <= i_enq_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_enq) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_deq) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_enq, w_do_deq})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/fetch_line_buffer.sv
// rtl/fetch_line_buffer.sv - fetch PC owner: line requests to the icache, line queue, one insn per cycle to decode
module fetch_line_buffer
    import FetchTypes::*;
#(
    parameter int                     LINE_SIZE   = FETCH_LINE_SIZE,
    parameter int                     PADDR_WIDTH = FETCH_PADDR_WIDTH,
    parameter int                     QUEUE_DEPTH = 4,
    parameter logic [PADDR_WIDTH-1:0] RESET_PC    = PADDR_WIDTH'(32'h8000_0000)
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic                     cacheFetchEnable,
    output logic [PADDR_WIDTH-1:0]   cacheAddr,
    input  logic                     cacheStall,
    input  logic                     cacheValid,
    input  logic                     cacheMiss,
    input  logic [LINE_SIZE*8-1:0]   cacheReadValue,
    input  logic                     redirectValid,
    input  logic [PADDR_WIDTH-1:0]   redirectPc,
    output logic                     decodeValid,
    output logic [31:0]              decodeInsn,
    output logic [PADDR_WIDTH-1:0]   decodePc,
    input  logic                     decodeReady
);

    localparam int OFF_W = $clog2(LINE_SIZE);
    localparam int WORDS = LINE_SIZE / 4;
    localparam int CNT_W = $clog2(QUEUE_DEPTH) + 1;

    FetchState                r_state, w_next_state;
    logic [PADDR_WIDTH-1:0]   r_pc, w_next_pc;
    logic                     r_kill, w_next_kill;
    logic [FETCH_START_W-1:0] r_head_word, w_next_head_word;

    logic                     w_issue;
    logic                     w_enq;
    logic                     w_fire;
    logic                     w_pop;
    logic                     w_empty;
    logic                     w_full;
    logic [CNT_W-1:0]         w_count;
    logic [PADDR_WIDTH-1:0]   w_line_addr;
    logic [PADDR_WIDTH-1:0]   w_redirect_pc;
    logic [FETCH_START_W-1:0] w_start_word;
    FetchLineEntry            w_enq_entry;
    FetchLineEntry            w_head;
    FetchLineEntry            w_next_entry;

    assign w_line_addr   = {r_pc[PADDR_WIDTH-1:OFF_W], OFF_W'(0)};
    assign w_redirect_pc = redirectPc & ~PADDR_WIDTH'(3);
    assign w_start_word  = FETCH_START_W'(r_pc[OFF_W-1:0] >> 2);

    assign w_enq_entry.lineAddr  = w_line_addr;
    assign w_enq_entry.line      = cacheReadValue;
    assign w_enq_entry.startWord = w_start_word;

    fetch_line_queue #(
        .WIDTH ($bits(FetchLineEntry)),
        .DEPTH (QUEUE_DEPTH)
    ) u_queue (
        .clk        (clk),
        .rst        (rst),
        .i_enq      (w_enq),
        .i_enq_data (w_enq_entry),
        .i_deq      (w_pop),
        .i_flush    (redirectValid),
        .o_head     (w_head),
        .o_next     (w_next_entry),
        .o_count    (w_count),
        .o_empty    (w_empty),
        .o_full     (w_full)
    );

    // Refill issues as soon as the stall drops, so it shares the Issue gating.
    always_comb begin
        w_next_state = r_state;
        w_next_pc    = r_pc;
        w_next_kill  = r_kill;
        w_issue      = 1'b0;
        w_enq        = 1'b0;
        case (r_state)
            Issue, Refill: begin
                if (!rst && !cacheStall && !redirectValid && !w_full) begin
                    w_issue      = 1'b1;
                    w_next_state = Wait;
                end
            end
            Wait: begin
                w_next_state = Issue;
                w_next_kill  = 1'b0;
                if (redirectValid && !r_kill) begin
                    w_next_kill  = 1'b1;
                    w_next_state = Wait;
                end else if (!r_kill && cacheValid) begin
                    w_enq     = 1'b1;
                    w_next_pc = w_line_addr + PADDR_WIDTH'(LINE_SIZE);
                end else if (!r_kill && cacheMiss) begin
                    w_next_state = Refill;
                end
            end
            default: w_next_state = Issue;
        endcase
        if (redirectValid) begin
            w_next_pc = w_redirect_pc;
        end
    end

    assign cacheFetchEnable = w_issue;
    assign cacheAddr        = w_line_addr;

    assign decodeValid = !w_empty && !redirectValid && !rst;
    assign decodeInsn  = w_head.line[32*r_head_word +: 32];
    assign decodePc    = w_head.lineAddr | (PADDR_WIDTH'(r_head_word) << 2);
    assign w_fire      = decodeValid && decodeReady;
    assign w_pop       = w_fire && (r_head_word == FETCH_START_W'(WORDS - 1));

    // A pop with a simultaneous enqueue into a one-entry queue takes the new line's start.
    always_comb begin
        w_next_head_word = r_head_word;
        if (w_pop) begin
            if (w_count > CNT_W'(1)) begin
                w_next_head_word = w_next_entry.startWord;
            end else if (w_enq) begin
                w_next_head_word = w_start_word;
            end
        end else if (w_fire) begin
            w_next_head_word = r_head_word + 1'b1;
        end else if (w_empty && w_enq) begin
            w_next_head_word = w_start_word;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= Issue;
            r_pc        <= RESET_PC;
            r_kill      <= 1'b0;
            r_head_word <= '0;
        end else begin
            r_state     <= w_next_state;
            r_pc        <= w_next_pc;
            r_kill      <= w_next_kill;
            r_head_word <= w_next_head_word;
        end
    end

endmodule

// File: tb/tb_fetch_line_buffer.sv
// tb/tb_fetch_line_buffer.sv - directed bench for fetch_line_buffer with hand-computed expectations
module tb_fetch_line_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        cacheFetchEnable;
    logic [31:0] cacheAddr;
    logic        cacheStall;
    logic        cacheValid;
    logic        cacheMiss;
    logic [63:0] cacheReadValue;
    logic        redirectValid;
    logic [31:0] redirectPc;
    logic        decodeValid;
    logic [31:0] decodeInsn;
    logic [31:0] decodePc;
    logic        decodeReady;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fetch_line_buffer dut (
        .clk              (clk),
        .rst              (rst),
        .cacheFetchEnable (cacheFetchEnable),
        .cacheAddr        (cacheAddr),
        .cacheStall       (cacheStall),
        .cacheValid       (cacheValid),
        .cacheMiss        (cacheMiss),
        .cacheReadValue   (cacheReadValue),
        .redirectValid    (redirectValid),
        .redirectPc       (redirectPc),
        .decodeValid      (decodeValid),
        .decodeInsn       (decodeInsn),
        .decodePc         (decodePc),
        .decodeReady      (decodeReady)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        rst = 1'b1;
        cacheStall = 1'b0;
        cacheValid = 1'b0;
        cacheMiss = 1'b0;
        cacheReadValue = '0;
        redirectValid = 1'b0;
        redirectPc = '0;
        decodeReady = 1'b0;
        step();
        step();
        chk("rst_fe", cacheFetchEnable, 0);
        chk("rst_dv", decodeValid, 0);

        // Test 1: first hit, two instructions, next line address
        rst = 1'b0;
        #1;
        chk("t1_fe", cacheFetchEnable, 1);
        chk("t1_addr", cacheAddr, 64'h8000_0000);
        decodeReady = 1'b1;
        step();
        cacheValid = 1'b1;
        cacheReadValue = {32'h0020_0093, 32'h0010_0013};
        #1;
        chk("t1_wait_fe", cacheFetchEnable, 0);
        chk("t1_wait_dv", decodeValid, 0);
        step();
        cacheValid = 1'b0;
        #1;
        chk("t1_dv0", decodeValid, 1);
        chk("t1_pc0", decodePc, 64'h8000_0000);
        chk("t1_insn0", decodeInsn, 64'h0010_0013);
        chk("t1_next_fe", cacheFetchEnable, 1);
        chk("t1_next_addr", cacheAddr, 64'h8000_0008);
        step();
        chk("t1_pc1", decodePc, 64'h8000_0004);
        chk("t1_insn1", decodeInsn, 64'h0020_0093);
        cacheValid = 1'b1;
        cacheReadValue = {32'h0040_0113, 32'h0030_0093};
        step();
        cacheValid = 1'b0;
        #1;
        chk("t1_pc2", decodePc, 64'h8000_0008);
        chk("t1_insn2", decodeInsn, 64'h0030_0093);

        // Test 2: miss, stall, reissue on first cycle of stall low
        chk("t2_addr", cacheAddr, 64'h8000_0010);
        chk("t2_fe", cacheFetchEnable, 1);
        step();
        cacheMiss = 1'b1;
        #1;
        chk("t2_pc3", decodePc, 64'h8000_000C);
        chk("t2_insn3", decodeInsn, 64'h0040_0113);
        step();
        cacheMiss = 1'b0;
        cacheStall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("t2_stall_fe", cacheFetchEnable, 0);
            chk("t2_stall_dv", decodeValid, 0);
            step();
        end
        cacheStall = 1'b0;
        #1;
        chk("t2_reissue_fe", cacheFetchEnable, 1);
        chk("t2_reissue_addr", cacheAddr, 64'h8000_0010);
        step();
        cacheValid = 1'b1;
        cacheReadValue = {32'h0060_0193, 32'h0050_0113};
        step();
        cacheValid = 1'b0;
        #1;
        chk("t2_hit_dv", decodeValid, 1);
        chk("t2_hit_pc", decodePc, 64'h8000_0010);

        // Test 3: redirect to a mid-line PC
        redirectValid = 1'b1;
        redirectPc = 32'h8000_0106;
        #1;
        chk("t3_redir_dv", decodeValid, 0);
        chk("t3_redir_fe", cacheFetchEnable, 0);
        step();
        redirectValid = 1'b0;
        #1;
        chk("t3_fe", cacheFetchEnable, 1);
        chk("t3_addr", cacheAddr, 64'h8000_0100);
        chk("t3_flushed_dv", decodeValid, 0);
        step();
        cacheValid = 1'b1;
        cacheReadValue = {32'hAAAA_0001, 32'hBBBB_0000};
        step();
        cacheValid = 1'b0;
        #1;
        chk("t3_dv", decodeValid, 1);
        chk("t3_pc", decodePc, 64'h8000_0104);
        chk("t3_insn", decodeInsn, 64'hAAAA_0001);
        chk("t3_next_addr", cacheAddr, 64'h8000_0108);
        step();
        chk("t3_only_one_dv", decodeValid, 0);

        // Test 4: decode stalled, queue fills after exactly four lines
        decodeReady = 1'b0;
        cacheValid = 1'b1;
        cacheReadValue = {32'h8000_010C, 32'h8000_0108};
        step();
        cacheValid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            a = 32'h8000_0110 + 32'(8 * k);
            #1;
            chk("t4_fe", cacheFetchEnable, 1);
            chk("t4_addr", cacheAddr, {32'h0, a});
            step();
            cacheValid = 1'b1;
            cacheReadValue = {a + 32'h4, a};
            step();
            cacheValid = 1'b0;
        end
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t4_full_fe", cacheFetchEnable, 0);
            step();
        end
        chk("t4_full_addr", cacheAddr, 64'h8000_0128);
        decodeReady = 1'b1;
        #1;
        chk("t4_dv", decodeValid, 1);
        chk("t4_pc0", decodePc, 64'h8000_0108);
        chk("t4_insn0", decodeInsn, 64'h8000_0108);
        step();
        chk("t4_pc1", decodePc, 64'h8000_010C);
        chk("t4_insn1", decodeInsn, 64'h8000_010C);
        chk("t4_prepop_fe", cacheFetchEnable, 0);
        step();
        decodeReady = 1'b0;
        #1;
        chk("t4_pc_after_pop", decodePc, 64'h8000_0110);
        chk("t4_reenable_fe", cacheFetchEnable, 1);
        chk("t4_reenable_addr", cacheAddr, 64'h8000_0128);
        step();

        // Test 5: redirect while waiting, late hit is killed
        redirectValid = 1'b1;
        redirectPc = 32'h8000_0200;
        #1;
        chk("t5_redir_dv", decodeValid, 0);
        chk("t5_redir_fe", cacheFetchEnable, 0);
        step();
        redirectValid = 1'b0;
        cacheValid = 1'b1;
        cacheReadValue = {32'hDEAD_0004, 32'hDEAD_0000};
        #1;
        chk("t5_kill_fe", cacheFetchEnable, 0);
        chk("t5_kill_dv", decodeValid, 0);
        step();
        cacheValid = 1'b0;
        #1;
        chk("t5_dropped_dv", decodeValid, 0);
        chk("t5_fe", cacheFetchEnable, 1);
        chk("t5_addr", cacheAddr, 64'h8000_0200);

        // Test 6: address wrap, then reset during refill
        redirectValid = 1'b1;
        redirectPc = 32'hFFFF_FFF8;
        #1;
        chk("t6_redir_fe", cacheFetchEnable, 0);
        step();
        redirectValid = 1'b0;
        #1;
        chk("t6_addr", cacheAddr, 64'hFFFF_FFF8);
        step();
        cacheValid = 1'b1;
        cacheReadValue = {32'h1234_5678, 32'h0BAD_CAFE};
        step();
        cacheValid = 1'b0;
        #1;
        chk("t6_wrap_fe", cacheFetchEnable, 1);
        chk("t6_wrap_addr", cacheAddr, 64'h0000_0000);
        chk("t6_wrap_dvpc", decodePc, 64'hFFFF_FFF8);
        chk("t6_wrap_insn", decodeInsn, 64'h0BAD_CAFE);
        step();
        cacheMiss = 1'b1;
        step();
        cacheMiss = 1'b0;
        cacheStall = 1'b1;
        rst = 1'b1;
        #1;
        chk("t6_rst_fe", cacheFetchEnable, 0);
        chk("t6_rst_dv", decodeValid, 0);
        step();
        rst = 1'b0;
        cacheStall = 1'b0;
        #1;
        chk("t6_post_rst_fe", cacheFetchEnable, 1);
        chk("t6_post_rst_addr", cacheAddr, 64'h8000_0000);
        chk("t6_post_rst_dv", decodeValid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
